// File: rtl/wb_write_port.sv
// Writeback write-port controller: loads own the register file port, ALU results bypass or queue.
// Optional WB_LOAD_ALIGN_EN macro enables sub-word load extraction and sign/zero extension.
module wb_write_port #(
    parameter int unsigned FIFO_DEPTH = 2
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic                            alu_valid,
    output logic                            alu_ready,
    input  logic [4:0]                      alu_rd,
    input  logic [31:0]                     alu_data,
    input  logic                            ld_valid,
    input  logic [4:0]                      ld_rd,
    input  logic [31:0]                     ld_data,
    input  logic [2:0]                      ld_funct3,
    input  logic [1:0]                      ld_byte_off,
    output logic                            regfile_wr_en,
    output logic [31:0]                     wb_instruction,
    output logic [31:0]                     reg_wr_data,
    output logic [31:0]                     pending_mask,
    output logic [$clog2(FIFO_DEPTH+1)-1:0] fifo_count
);

    localparam int unsigned PtrW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned CntW = $clog2(FIFO_DEPTH + 1);

    logic [4:0]      fifo_rd   [FIFO_DEPTH];
    logic [31:0]     fifo_data [FIFO_DEPTH];
    logic [PtrW-1:0] rptr_q, wptr_q;
    logic [CntW-1:0] count_q;

    logic        wr_en_q, wr_en_d;
    logic [4:0]  wb_rd_q, wb_rd_d;
    logic [31:0] wr_data_q, wr_data_d;

    logic        fifo_empty, alu_acc, alu_keep, enq, deq;
    logic [31:0] ld_wdata;

    assign fifo_empty = (count_q == '0);
    assign alu_ready  = rst_n && (count_q < CntW'(FIFO_DEPTH));
    assign alu_acc    = alu_valid && alu_ready;
    // x0 results complete the handshake but are never written or queued
    assign alu_keep   = alu_acc && (alu_rd != 5'd0);
    assign deq        = !ld_valid && !fifo_empty;
    assign enq        = alu_keep && (ld_valid || !fifo_empty);

`ifdef WB_LOAD_ALIGN_EN
    logic [7:0]  ld_byte;
    logic [15:0] ld_half;

    always_comb begin
        case (ld_byte_off)
            2'd0:    ld_byte = ld_data[7:0];
            2'd1:    ld_byte = ld_data[15:8];
            2'd2:    ld_byte = ld_data[23:16];
            default: ld_byte = ld_data[31:24];
        endcase
        ld_half = ld_byte_off[1] ? ld_data[31:16] : ld_data[15:0];
        case (ld_funct3)
            3'b000:  ld_wdata = {{24{ld_byte[7]}}, ld_byte};
            3'b001:  ld_wdata = {{16{ld_half[15]}}, ld_half};
            3'b100:  ld_wdata = {24'd0, ld_byte};
            3'b101:  ld_wdata = {16'd0, ld_half};
            default: ld_wdata = ld_data;
        endcase
    end
`else
    // Alignment already done in the memory stage
    logic unused_ld_cfg;
    assign unused_ld_cfg = ^{ld_funct3, ld_byte_off};
    assign ld_wdata      = ld_data;
`endif

    always_comb begin
        wr_en_d   = 1'b0;
        wb_rd_d   = 5'd0;
        wr_data_d = 32'd0;
        if (ld_valid) begin
            if (ld_rd != 5'd0) begin
                wr_en_d   = 1'b1;
                wb_rd_d   = ld_rd;
                wr_data_d = ld_wdata;
            end
        end else if (!fifo_empty) begin
            wr_en_d   = 1'b1;
            wb_rd_d   = fifo_rd[rptr_q];
            wr_data_d = fifo_data[rptr_q];
        end else if (alu_keep) begin
            wr_en_d   = 1'b1;
            wb_rd_d   = alu_rd;
            wr_data_d = alu_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_en_q   <= 1'b0;
            wb_rd_q   <= 5'd0;
            wr_data_q <= 32'd0;
            rptr_q    <= '0;
            wptr_q    <= '0;
            count_q   <= '0;
        end else begin
            wr_en_q   <= wr_en_d;
            wb_rd_q   <= wb_rd_d;
            wr_data_q <= wr_data_d;
            if (deq) rptr_q <= rptr_q + PtrW'(1);
            if (enq) wptr_q <= wptr_q + PtrW'(1);
            case ({enq, deq})
                2'b10:   count_q <= count_q + CntW'(1);
                2'b01:   count_q <= count_q - CntW'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    // Payload storage needs no reset; occupancy alone defines validity
    always_ff @(posedge clk) begin
        if (enq) begin
            fifo_rd[wptr_q]   <= alu_rd;
            fifo_data[wptr_q] <= alu_data;
        end
    end

    always_comb begin
        pending_mask = 32'd0;
        if (wr_en_q) pending_mask[wb_rd_q] = 1'b1;
        for (int unsigned k = 0; k < FIFO_DEPTH; k++) begin
            if (k < 32'(count_q)) pending_mask[fifo_rd[rptr_q + PtrW'(k)]] = 1'b1;
        end
        pending_mask[0] = 1'b0;
    end

    assign regfile_wr_en  = wr_en_q;
    assign wb_instruction = {20'd0, wb_rd_q, 7'd0};
    assign reg_wr_data    = wr_data_q;
    assign fifo_count     = count_q;

endmodule

// File: tb/tb_wb_write_port.sv
// Directed testbench for wb_write_port (FIFO_DEPTH = 2); expectations follow WB_LOAD_ALIGN_EN.
module tb_wb_write_port;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        alu_valid, alu_ready;
    logic [4:0]  alu_rd;
    logic [31:0] alu_data;
    logic        ld_valid;
    logic [4:0]  ld_rd;
    logic [31:0] ld_data;
    logic [2:0]  ld_funct3;
    logic [1:0]  ld_byte_off;
    logic        regfile_wr_en;
    logic [31:0] wb_instruction, reg_wr_data, pending_mask;
    logic [1:0]  fifo_count;

    int n_cmp = 0;
    int n_err = 0;

    wb_write_port #(.FIFO_DEPTH(2)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .alu_valid     (alu_valid),
        .alu_ready     (alu_ready),
        .alu_rd        (alu_rd),
        .alu_data      (alu_data),
        .ld_valid      (ld_valid),
        .ld_rd         (ld_rd),
        .ld_data       (ld_data),
        .ld_funct3     (ld_funct3),
        .ld_byte_off   (ld_byte_off),
        .regfile_wr_en (regfile_wr_en),
        .wb_instruction(wb_instruction),
        .reg_wr_data   (reg_wr_data),
        .pending_mask  (pending_mask),
        .fifo_count    (fifo_count)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        alu_valid = 1'b0; alu_rd = 5'd0; alu_data = 32'd0;
        ld_valid = 1'b0; ld_rd = 5'd0; ld_data = 32'd0;
        ld_funct3 = 3'b010; ld_byte_off = 2'd0;
    endtask

    task automatic test_reset();
        idle_inputs();
        rst_n = 1'b0;
        repeat (3) tick();
        n_cmp++;
        if ({regfile_wr_en, wb_instruction, reg_wr_data} !== 65'd0) begin
            n_err++;
            $display("FAIL reset_outputs got %b/%h/%h want 0/0/0",
                     regfile_wr_en, wb_instruction, reg_wr_data);
        end
        n_cmp++;
        if (fifo_count !== 2'd0 || pending_mask !== 32'd0) begin
            n_err++;
            $display("FAIL reset_fifo got count %0d mask %h want 0/0", fifo_count, pending_mask);
        end
        n_cmp++;
        if (alu_ready !== 1'b0) begin
            n_err++;
            $display("FAIL reset_ready_low got %b want 0", alu_ready);
        end
        #3 rst_n = 1'b1;
        tick();
        n_cmp++;
        if (alu_ready !== 1'b1) begin
            n_err++;
            $display("FAIL reset_ready_high got %b want 1", alu_ready);
        end
    endtask

    task automatic test_bypass();
        alu_valid = 1'b1; alu_rd = 5'd5; alu_data = 32'hDEADBEEF;
        tick();
        idle_inputs();
        n_cmp++;
        if (regfile_wr_en !== 1'b1 || wb_instruction !== 32'h00000280) begin
            n_err++;
            $display("FAIL bypass_write got %b/%h want 1/00000280", regfile_wr_en, wb_instruction);
        end
        n_cmp++;
        if (reg_wr_data !== 32'hDEADBEEF || pending_mask !== 32'h00000020) begin
            n_err++;
            $display("FAIL bypass_data got %h/%h want deadbeef/00000020", reg_wr_data,
                     pending_mask);
        end
        tick();
        n_cmp++;
        if (regfile_wr_en !== 1'b0 || pending_mask !== 32'd0) begin
            n_err++;
            $display("FAIL bypass_done got %b/%h want 0/0", regfile_wr_en, pending_mask);
        end
    endtask

    task automatic test_load_and_alu();
        ld_valid = 1'b1; ld_rd = 5'd3; ld_data = 32'h12345678; ld_funct3 = 3'b010;
        alu_valid = 1'b1; alu_rd = 5'd7; alu_data = 32'h0000000A;
        tick();
        idle_inputs();
        n_cmp++;
        if (regfile_wr_en !== 1'b1 || wb_instruction !== 32'h00000180 ||
            reg_wr_data !== 32'h12345678) begin
            n_err++;
            $display("FAIL collide_load got %b/%h/%h want 1/00000180/12345678",
                     regfile_wr_en, wb_instruction, reg_wr_data);
        end
        n_cmp++;
        if (fifo_count !== 2'd1 || pending_mask !== 32'h00000088) begin
            n_err++;
            $display("FAIL collide_queue got %0d/%h want 1/00000088", fifo_count, pending_mask);
        end
        tick();
        n_cmp++;
        if (regfile_wr_en !== 1'b1 || wb_instruction !== 32'h00000380 ||
            reg_wr_data !== 32'h0000000A) begin
            n_err++;
            $display("FAIL collide_alu got %b/%h/%h want 1/00000380/0000000a",
                     regfile_wr_en, wb_instruction, reg_wr_data);
        end
        n_cmp++;
        if (fifo_count !== 2'd0 || pending_mask !== 32'h00000080) begin
            n_err++;
            $display("FAIL collide_drain got %0d/%h want 0/00000080", fifo_count, pending_mask);
        end
        tick();
    endtask

    task automatic test_back_to_back();
        // Per-edge expectations: write enable, rd written, data, count, alu_ready
        logic [4:0]  e_rd   [8];
        logic [31:0] e_data [8];
        logic [1:0]  e_cnt  [8];
        logic        e_rdy  [8];
        logic        e_wen  [8];
        e_wen  = '{1, 1, 1, 1, 1, 1, 1, 0};
        e_rd   = '{10, 11, 12, 13, 1, 2, 3, 0};
        e_data = '{32'h1000000A, 32'h1000000B, 32'h1000000C, 32'h1000000D,
                   32'hA0000001, 32'hA0000002, 32'hA0000003, 32'h0};
        e_cnt  = '{1, 2, 2, 2, 1, 1, 0, 0};
        e_rdy  = '{1, 0, 0, 0, 1, 1, 1, 1};
        alu_valid = 1'b1; alu_rd = 5'd1; alu_data = 32'hA0000001;
        for (int i = 0; i < 8; i++) begin
            logic acc;
            ld_valid = (i < 4);
            ld_rd    = (i < 4) ? 5'(10 + i) : 5'd0;
            ld_data  = 32'h10000000 | 32'(10 + i);
            acc = alu_valid && alu_ready;
            tick();
            if (acc) begin
                if (alu_rd == 5'd3) begin
                    alu_valid = 1'b0;
                end else begin
                    alu_rd   = alu_rd + 5'd1;
                    alu_data = 32'hA0000000 | 32'(alu_rd);
                end
            end
            n_cmp++;
            if (regfile_wr_en !== e_wen[i] || wb_instruction !== {20'd0, e_rd[i], 7'd0} ||
                (e_wen[i] && reg_wr_data !== e_data[i])) begin
                n_err++;
                $display("FAIL b2b_write[%0d] got %b/%h/%h want %b/%h/%h", i, regfile_wr_en,
                         wb_instruction, reg_wr_data, e_wen[i], {20'd0, e_rd[i], 7'd0},
                         e_data[i]);
            end
            n_cmp++;
            if (fifo_count !== e_cnt[i] || alu_ready !== e_rdy[i]) begin
                n_err++;
                $display("FAIL b2b_fifo[%0d] got %0d/%b want %0d/%b", i, fifo_count, alu_ready,
                         e_cnt[i], e_rdy[i]);
            end
        end
        idle_inputs();
    endtask

    task automatic test_rd_zero();
        alu_valid = 1'b1; alu_rd = 5'd0; alu_data = 32'h55555555;
        ld_valid = 1'b1; ld_rd = 5'd0; ld_data = 32'h66666666;
        n_cmp++;
        if (alu_ready !== 1'b1) begin
            n_err++;
            $display("FAIL x0_ready got %b want 1", alu_ready);
        end
        tick();
        ld_valid = 1'b0;
        n_cmp++;
        if (regfile_wr_en !== 1'b0 || fifo_count !== 2'd0 || pending_mask !== 32'd0) begin
            n_err++;
            $display("FAIL x0_both got %b/%0d/%h want 0/0/0", regfile_wr_en, fifo_count,
                     pending_mask);
        end
        tick();
        idle_inputs();
        n_cmp++;
        if (regfile_wr_en !== 1'b0 || fifo_count !== 2'd0) begin
            n_err++;
            $display("FAIL x0_alu got %b/%0d want 0/0", regfile_wr_en, fifo_count);
        end
    endtask

    task automatic test_load_align();
        logic [2:0]  f3  [6];
        logic [1:0]  off [6];
        logic [31:0] exp [6];
        f3  = '{3'b000, 3'b100, 3'b001, 3'b101, 3'b010, 3'b011};
        off = '{2'd3, 2'd0, 2'd2, 2'd1, 2'd0, 2'd2};
`ifdef WB_LOAD_ALIGN_EN
        exp = '{32'hFFFFFF80, 32'h000000AB, 32'hFFFF8077, 32'h0000F0AB, 32'h8077F0AB,
                32'h8077F0AB};
`else
        exp = '{32'h8077F0AB, 32'h8077F0AB, 32'h8077F0AB, 32'h8077F0AB, 32'h8077F0AB,
                32'h8077F0AB};
`endif
        for (int i = 0; i < 6; i++) begin
            ld_valid = 1'b1; ld_rd = 5'd9; ld_data = 32'h8077F0AB;
            ld_funct3 = f3[i]; ld_byte_off = off[i];
            tick();
            n_cmp++;
            if (regfile_wr_en !== 1'b1 || reg_wr_data !== exp[i]) begin
                n_err++;
                $display("FAIL align[%0d] f3=%b off=%0d got %b/%h want 1/%h", i, f3[i], off[i],
                         regfile_wr_en, reg_wr_data, exp[i]);
            end
        end
        idle_inputs();
        tick();
    endtask

    task automatic test_reset_mid();
        ld_valid = 1'b1; ld_rd = 5'd20; ld_data = 32'h20202020;
        alu_valid = 1'b1; alu_rd = 5'd4; alu_data = 32'h44444444;
        tick();
        alu_rd = 5'd5; alu_data = 32'h55555555;
        tick();
        idle_inputs();
        n_cmp++;
        if (fifo_count !== 2'd2 || pending_mask !== 32'h00100030) begin
            n_err++;
            $display("FAIL rstmid_setup got %0d/%h want 2/00100030", fifo_count, pending_mask);
        end
        #2 rst_n = 1'b0;
        #1;
        n_cmp++;
        if ({regfile_wr_en, wb_instruction, reg_wr_data} !== 65'd0 || fifo_count !== 2'd0 ||
            pending_mask !== 32'd0 || alu_ready !== 1'b0) begin
            n_err++;
            $display("FAIL rstmid_clear got %b/%h/%h/%0d/%h/%b want all 0", regfile_wr_en,
                     wb_instruction, reg_wr_data, fifo_count, pending_mask, alu_ready);
        end
        #2 rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            n_cmp++;
            if (regfile_wr_en !== 1'b0 || fifo_count !== 2'd0) begin
                n_err++;
                $display("FAIL rstmid_after[%0d] got %b/%0d want 0/0", i, regfile_wr_en,
                         fifo_count);
            end
        end
    endtask

    initial begin
        test_reset();
        test_bypass();
        test_load_and_alu();
        test_back_to_back();
        test_rd_zero();
        test_load_align();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
